// File: rtl/cochlea_phase_event_ctrl.sv
// cochlea_phase_event_ctrl: non-overlapping two-phase switch-clock generator with comparator change-event FIFO
module cochlea_phase_event_ctrl #(
    parameter int N_CH       = 4,
    parameter int CNT_W      = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = $clog2(N_CH),
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int EV_W      = TS_W + CH_W + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] phi_len_i,
    input  logic [CNT_W-1:0] gap_len_i,
    input  logic [N_CH-1:0]  comp_i,
    output logic             phi1_o,
    output logic             phi2_o,
    output logic             phi1b_o,
    output logic             phi2b_o,
    output logic             ev_valid_o,
    output logic [EV_W-1:0]  ev_data_o,
    input  logic             ev_ready_i,
    output logic             ovf_o,
    input  logic             clr_ovf_i,
    output logic [AW:0]      fifo_cnt_o
);
    typedef enum logic [2:0] {IDLE, PHI1, GAP1, PHI2, GAP2} state_t;
    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] phi_ld;
    logic [CNT_W-1:0] gap_ld;
    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;
    logic [N_CH-1:0] prev;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] diff;
    logic [N_CH-1:0] pend_left;
    logic [N_CH-1:0] push_mask;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ev_ts [N_CH];
    logic base;
    logic sample_now;
    logic found;
    logic refire;
    logic push;
    logic pop;
    logic drop;
    logic full;
    logic empty;
    logic [CH_W-1:0] sel;
    logic [EV_W-1:0] push_data;
    logic [EV_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count;

    // The counter holds remaining cycles minus one, so a zero length still lasts one cycle
    assign phi_ld = (phi_len_i == '0) ? '0 : phi_len_i - 1'b1;
    assign gap_ld = (gap_len_i == '0) ? '0 : gap_len_i - 1'b1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            phi1_o  <= 1'b0;
            phi1b_o <= 1'b1;
            phi2_o  <= 1'b0;
            phi2b_o <= 1'b1;
        end else if (state == IDLE) begin
            if (enable_i) begin
                state   <= PHI1;
                cnt     <= phi_ld;
                phi1_o  <= 1'b1;
                phi1b_o <= 1'b0;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            case (state)
                PHI1: begin
                    state   <= GAP1;
                    cnt     <= gap_ld;
                    phi1_o  <= 1'b0;
                    phi1b_o <= 1'b1;
                end
                GAP1: begin
                    state   <= PHI2;
                    cnt     <= phi_ld;
                    phi2_o  <= 1'b1;
                    phi2b_o <= 1'b0;
                end
                PHI2: begin
                    state   <= GAP2;
                    cnt     <= gap_ld;
                    phi2_o  <= 1'b0;
                    phi2b_o <= 1'b1;
                end
                default: begin
                    state   <= enable_i ? PHI1 : IDLE;
                    cnt     <= phi_ld;
                    phi1_o  <= enable_i;
                    phi1b_o <= !enable_i;
                end
            endcase
        end
    end

    assign sample_now = (state == PHI2) && (cnt == '0);
    assign diff       = (sample_now && !base) ? (sync2 ^ prev) : '0;

    always_comb begin
        sel = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (pending[i]) sel = CH_W'(i);
    end

    assign found     = |pending;
    assign push_mask = found ? (N_CH'(1) << sel) : '0;
    assign pend_left = pending & ~push_mask;
    assign refire    = |(pend_left & diff);
    assign full      = count == (AW+1)'(FIFO_DEPTH);
    assign empty     = count == '0;
    assign pop       = !empty && ev_ready_i;
    assign push      = found && (!full || pop);
    assign drop      = found && full && !pop;
    // prev already holds the newest sample, so it is the polarity of the pending change
    assign push_data = {ev_ts[sel], sel, prev[sel]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1   <= '0;
            sync2   <= '0;
            prev    <= '0;
            pending <= '0;
            ts      <= '0;
            base    <= 1'b1;
            ovf_o   <= 1'b0;
            for (int k = 0; k < N_CH; k++)
                ev_ts[k] <= '0;
        end else begin
            sync1   <= comp_i;
            sync2   <= sync1;
            pending <= pend_left | diff;
            ovf_o   <= refire | drop | (ovf_o & ~clr_ovf_i);
            if (state == IDLE)
                base <= 1'b1;
            else if (sample_now)
                base <= 1'b0;
            if (sample_now) begin
                prev <= sync2;
                ts   <= ts + 1'b1;
            end
            for (int k = 0; k < N_CH; k++)
                if (diff[k]) ev_ts[k] <= ts;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge wb_clk_i)
        if (push) mem[wr_ptr] <= push_data;

    assign ev_valid_o = !empty;
    assign ev_data_o  = empty ? '0 : mem[rd_ptr];
    assign fifo_cnt_o = count;
endmodule

// File: tb/tb_cochlea_phase_event_ctrl.sv
// tb_cochlea_phase_event_ctrl: randomized and directed checks against a phase-arithmetic and event-queue model
module tb_cochlea_phase_event_ctrl;
    localparam int N_CH = 4, CNT_W = 8, TS_W = 16, FIFO_DEPTH = 8;
    localparam int CH_W = 2, EV_W = TS_W + CH_W + 1, FC_W = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_ni = 1'b1;
    logic enable_i = 1'b0;
    logic ev_ready_i = 1'b0;
    logic clr_ovf_i = 1'b0;
    logic [CNT_W-1:0] phi_len_i = 8'd3;
    logic [CNT_W-1:0] gap_len_i = 8'd1;
    logic [N_CH-1:0] comp_i = '0;
    logic phi1_o, phi2_o, phi1b_o, phi2b_o;
    logic ev_valid_o;
    logic [EV_W-1:0] ev_data_o;
    logic ovf_o;
    logic [FC_W-1:0] fifo_cnt_o;

    always #5 wb_clk_i = ~wb_clk_i;

    cochlea_phase_event_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .TS_W(TS_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .enable_i(enable_i),
        .phi_len_i(phi_len_i), .gap_len_i(gap_len_i), .comp_i(comp_i),
        .phi1_o(phi1_o), .phi2_o(phi2_o), .phi1b_o(phi1b_o), .phi2b_o(phi2b_o),
        .ev_valid_o(ev_valid_o), .ev_data_o(ev_data_o), .ev_ready_i(ev_ready_i),
        .ovf_o(ovf_o), .clr_ovf_i(clr_ovf_i), .fifo_cnt_o(fifo_cnt_o)
    );

    int n_chk = 0;
    int n_pass = 0;
    int j, p_eff, g_eff, per, stop_end, cap;
    logic [N_CH-1:0] m_prev;
    logic [EV_W-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Expected {phi1, phi2, phi1b, phi2b} for view j counted from the first PHI1 cycle
    function automatic logic [3:0] exp_phase(input int jj);
        int r;
        logic a, b;
        if (jj >= stop_end) return 4'b0011;
        r = jj % per;
        a = r < p_eff;
        b = (r >= p_eff + g_eff) && (r < 2 * p_eff + g_eff);
        return {a, b, ~a, ~b};
    endfunction

    task automatic step();
        if (ev_valid_o && ev_ready_i) begin
            if (exp_q.size() == 0) chk("ev_extra", ev_valid_o, 1'b0);
            else chk("ev_data", ev_data_o, exp_q.pop_front());
        end
        @(posedge wb_clk_i);
        #1;
        j++;
        chk("phase", {phi1_o, phi2_o, phi1b_o, phi2b_o}, exp_phase(j));
    endtask

    task automatic run_to(input int target);
        while (j < target) step();
    endtask

    // Called on the first PHI1 view of a period; that period's sample sees value v
    task automatic drive_comp(input logic [N_CH-1:0] v);
        int n;
        n = j / per;
        for (int k = 0; k < N_CH; k++)
            if (v[k] !== m_prev[k] && exp_q.size() < cap)
                exp_q.push_back({TS_W'(n), CH_W'(k), v[k]});
        m_prev = v;
        comp_i = v;
    endtask

    task automatic start(input int p, input int g, input logic [N_CH-1:0] init);
        enable_i = 1'b0;
        ev_ready_i = 1'b0;
        clr_ovf_i = 1'b0;
        wb_rst_ni = 1'b0;
        comp_i = init;
        phi_len_i = CNT_W'(p);
        gap_len_i = CNT_W'(g);
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        #1;
        p_eff = (p == 0) ? 1 : p;
        g_eff = (g == 0) ? 1 : g;
        per = 2 * (p_eff + g_eff);
        stop_end = 1 << 30;
        cap = 1000;
        m_prev = init;
        exp_q.delete();
        enable_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        j = 0;
        chk("phase_start", {phi1_o, phi2_o, phi1b_o, phi2b_o}, exp_phase(0));
    endtask

    initial begin
        #1 wb_rst_ni = 1'b0;
        #1;
        chk("rst_phase", {phi1_o, phi2_o, phi1b_o, phi2b_o}, 4'b0011);
        chk("rst_valid", ev_valid_o, 1'b0);
        chk("rst_data", ev_data_o, '0);
        chk("rst_cnt", fifo_cnt_o, '0);
        chk("rst_ovf", ovf_o, 1'b0);

        // 3/1 phasing, nonzero baseline, single-channel change, all-toggle, then enable drop
        start(3, 1, 4'b1010);
        run_to(8);
        drive_comp(4'b1110);
        run_to(16);
        chk("baseline_cnt", fifo_cnt_o, 1);
        chk("first_event", ev_data_o, {16'd1, 2'd2, 1'b1});
        ev_ready_i = 1'b1;
        run_to(32);
        chk("first_missing", exp_q.size(), 0);
        ev_ready_i = 1'b0;
        drive_comp(4'b0001);
        for (int i = 0; i < 20 && fifo_cnt_o == 0; i++) step();
        chk("burst_cnt", fifo_cnt_o, 1);
        for (int k = 2; k <= 4; k++) begin
            step();
            chk("burst_cnt", fifo_cnt_o, k);
        end
        chk("burst_head", ev_data_o[EV_W-1:1], {16'd4, 2'd0});
        ev_ready_i = 1'b1;
        run_to(48);
        chk("burst_missing", exp_q.size(), 0);
        enable_i = 1'b0;
        stop_end = 56;
        run_to(72);
        chk("idle_valid", ev_valid_o, 1'b0);

        // Fill with ready low: eight entries fit, the ninth is dropped
        start(3, 1, 4'b0000);
        cap = FIFO_DEPTH;
        run_to(8);
        drive_comp(4'b1111);
        run_to(16);
        drive_comp(4'b0000);
        run_to(24);
        drive_comp(4'b0001);
        run_to(28);
        chk("full_cnt", fifo_cnt_o, 8);
        chk("full_no_ovf", ovf_o, 1'b0);
        run_to(36);
        chk("drop_cnt", fifo_cnt_o, exp_q.size());
        chk("drop_ovf", ovf_o, 1'b1);
        clr_ovf_i = 1'b1;
        step();
        clr_ovf_i = 1'b0;
        chk("clr_ovf", ovf_o, 1'b0);
        ev_ready_i = 1'b1;
        run_to(48);
        chk("drop_missing", exp_q.size(), 0);
        chk("drop_empty", ev_valid_o, 1'b0);

        // Asynchronous reset in PHI2 with three queued events
        start(3, 1, 4'b0000);
        run_to(8);
        drive_comp(4'b0111);
        run_to(20);
        chk("pre_rst_cnt", fifo_cnt_o, 3);
        #2 wb_rst_ni = 1'b0;
        enable_i = 1'b0;
        #1;
        chk("arst_phase", {phi1_o, phi2_o, phi1b_o, phi2b_o}, 4'b0011);
        chk("arst_cnt", fifo_cnt_o, 0);
        chk("arst_valid", ev_valid_o, 1'b0);
        chk("arst_data", ev_data_o, '0);
        @(posedge wb_clk_i);
        #1 wb_rst_ni = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        chk("post_rst_phase", {phi1_o, phi2_o, phi1b_o, phi2b_o}, 4'b0011);
        chk("post_rst_cnt", fifo_cnt_o, 0);

        // Random lengths, comparator patterns and back-pressure
        for (int r = 0; r < 6; r++) begin
            int p, g;
            p = $urandom_range(0, 4);
            g = $urandom_range(0, 4);
            if (((p == 0) ? 1 : p) + ((g == 0) ? 1 : g) < 3) g = 3;
            start(p, g, N_CH'($urandom));
            while (j < 11 * per) begin
                if (j > 0 && j % per == 0) drive_comp(N_CH'($urandom));
                ev_ready_i = (j % 4 != 3) || ($urandom_range(0, 1) == 1);
                step();
            end
            ev_ready_i = 1'b1;
            run_to(13 * per);
            chk("rnd_missing", exp_q.size(), 0);
            chk("rnd_ovf", ovf_o, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
